// File: rtl/mips_pkg.sv
// Shared MIPS front-end constants: word width, NOP encoding and sequential PC step.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mips_pkg;

    localparam int          MIPS_WORD_W = 32;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam int          PC_STEP     = 4;

endpackage : mips_pkg

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the memory port and decode, with a sticky PC-continuity checker.
// Latency: a pushed word reaches dec_* one cycle after its push; no flow-through when empty.
// Backpressure: mem_ready = not full, from registered occupancy only (a full queue refuses a push even on a same-cycle pop).
//
// Ports:
//   clk, reset             single clock, synchronous active-high reset
//   mem_valid/mem_ready    fetch handshake carrying mem_pc, mem_instr
//   dec_valid/dec_ready    decode handshake carrying dec_pc, dec_instr (NOP/0 when empty)
//   flush                  drop all entries and forget the expected PC
//   count                  current occupancy
//   seq_err                sticky flag: an accepted PC broke the sequential stream
module fetch_queue
    import mips_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WORD_W = MIPS_WORD_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_valid,
    input  logic [WORD_W-1:0]       mem_pc,
    input  logic [WORD_W-1:0]       mem_instr,
    output logic                    mem_ready,
    output logic                    dec_valid,
    output logic [WORD_W-1:0]       dec_instr,
    output logic [WORD_W-1:0]       dec_pc,
    input  logic                    dec_ready,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    seq_err
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WORD_W-1:0] pc_mem    [DEPTH];
    logic [WORD_W-1:0] instr_mem [DEPTH];
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [WORD_W-1:0] exp_pc;
    logic              exp_pc_vld;
    logic              push;
    logic              pop;

    assign mem_ready = (count != FULL_CNT);
    assign dec_valid = (count != '0);

    // Flush wins over both handshakes in its cycle.
    assign push = mem_valid && mem_ready && !flush;
    assign pop  = dec_valid && dec_ready && !flush;

    assign dec_instr = dec_valid ? instr_mem[head] : WORD_W'(NOP_INSTR);
    assign dec_pc    = dec_valid ? pc_mem[head]    : '0;

    // Entry storage carries no reset; contents only matter while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]    <= mem_pc;
            instr_mem[tail] <= mem_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // Power-of-two depth: pointer overflow is the modulo wrap.
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Continuity checker: the first push after reset/flush only seeds exp_pc.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            exp_pc     <= '0;
            exp_pc_vld <= 1'b0;
            seq_err    <= 1'b0;
        end else if (push) begin
            exp_pc     <= mem_pc + WORD_W'(PC_STEP);
            exp_pc_vld <= 1'b1;
            if (exp_pc_vld && (mem_pc != exp_pc)) seq_err <= 1'b1;
        end
    end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a scoreboard: accepted pushes queue the expected
// {pc, instr}; an independent negedge monitor pops and compares on every decode handshake.
// Status checks (count, flags) are made #1 after the active edge.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic [31:0] mem_instr;
    logic        mem_ready;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready;
    logic        flush;
    logic [2:0]  count;
    logic        seq_err;

    int          n_vec  = 0;
    int          n_fail = 0;
    int          pop_cnt = 0;
    logic [63:0] exp_q [$];

    fetch_queue #(.DEPTH(4), .WORD_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_pc    (mem_pc),
        .mem_instr (mem_instr),
        .mem_ready (mem_ready),
        .dec_valid (dec_valid),
        .dec_instr (dec_instr),
        .dec_pc    (dec_pc),
        .dec_ready (dec_ready),
        .flush     (flush),
        .count     (count),
        .seq_err   (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // One clock cycle of stimulus, entered and left at posedge+1.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        mem_valid = v;
        mem_pc    = pc;
        mem_instr = instr_of(pc);
        dec_ready = rdy;
        flush     = fl;
        @(negedge clk);
        if (v && mem_ready && !fl && !reset) exp_q.push_back({pc, instr_of(pc)});
        @(posedge clk);
        #1;
        if (fl || reset) exp_q.delete();
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin : monitor
        logic [63:0] e;
        if (!reset && !flush && dec_valid && dec_ready) begin
            n_vec++;
            pop_cnt++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: dec_pc=%h dec_instr=%h, expected no entry", dec_pc, dec_instr);
            end else begin
                e = exp_q.pop_front();
                if ({dec_pc, dec_instr} !== e) begin
                    n_fail++;
                    $display("FAIL pop_data: got pc=%h instr=%h, expected pc=%h instr=%h",
                             dec_pc, dec_instr, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int p0;
        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_pc    = '0;
        mem_instr = '0;
        dec_ready = 1'b0;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count",     32'(count),     32'd0);
        check("rst_dec_valid", 32'(dec_valid), 32'd0);
        check("rst_dec_instr", dec_instr,      32'h0);
        check("rst_dec_pc",    dec_pc,         32'h0);
        check("rst_mem_ready", 32'(mem_ready), 32'd1);
        check("rst_seq_err",   32'(seq_err),   32'd0);
        reset = 1'b0;

        // Three sequential pushes, decode stalled; no flow-through on the first.
        mem_valid = 1'b1;
        mem_pc    = 32'h0;
        #1;
        check("no_flow_through", 32'(dec_valid), 32'd0);
        cyc(1'b1, 32'h0, 1'b0, 1'b0);
        check("first_visible", 32'(dec_valid), 32'd1);
        cyc(1'b1, 32'h4, 1'b0, 1'b0);
        cyc(1'b1, 32'h8, 1'b0, 1'b0);
        check("three_count",   32'(count),   32'd3);
        check("three_dec_pc",  dec_pc,       32'h0);
        check("three_instr",   dec_instr,    32'hC0DE_0000);
        check("three_seq_err", 32'(seq_err), 32'd0);
        repeat (3) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("drain_count", 32'(count), 32'd0);

        // Full queue refuses a push even while decode pops.
        cyc(1'b1, 32'hC,  1'b0, 1'b0);
        cyc(1'b1, 32'h10, 1'b0, 1'b0);
        cyc(1'b1, 32'h14, 1'b0, 1'b0);
        cyc(1'b1, 32'h18, 1'b0, 1'b0);
        check("full_count",     32'(count),     32'd4);
        check("full_mem_ready", 32'(mem_ready), 32'd0);
        cyc(1'b1, 32'h1C, 1'b1, 1'b0);
        check("full_pop_count", 32'(count),     32'd3);
        check("refill_ready",   32'(mem_ready), 32'd1);
        cyc(1'b1, 32'h1C, 1'b1, 1'b0);
        check("push_pop_count", 32'(count),     32'd3);
        repeat (3) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("full_seq_err",   32'(seq_err),   32'd0);

        // Streaming 0x0..0x24 through a depth-4 queue: pointers wrap twice.
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        p0 = pop_cnt;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 32'(4 * i), 1'b1, 1'b0);
            if (i == 5) check("stream_count", 32'(count), 32'd1);
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("stream_pops",    32'(pop_cnt - p0), 32'd10);
        check("stream_empty",   32'(count),        32'd0);
        check("stream_seq_err", 32'(seq_err),      32'd0);

        // Flush with three queued and a simultaneous push.
        cyc(1'b1, 32'h28, 1'b0, 1'b0);
        cyc(1'b1, 32'h2C, 1'b0, 1'b0);
        cyc(1'b1, 32'h30, 1'b0, 1'b0);
        cyc(1'b1, 32'h100, 1'b0, 1'b1);
        check("flush_count",     32'(count),     32'd0);
        check("flush_dec_valid", 32'(dec_valid), 32'd0);
        check("flush_dec_instr", dec_instr,      32'h0);
        check("flush_mem_ready", 32'(mem_ready), 32'd1);
        cyc(1'b1, 32'h200, 1'b0, 1'b0);
        check("post_flush_seq_err", 32'(seq_err), 32'd0);
        check("post_flush_count",   32'(count),   32'd1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // PC discontinuity: 0x0 then 0x10.
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b1, 32'h0, 1'b0, 1'b0);
        check("seq_first",  32'(seq_err), 32'd0);
        cyc(1'b1, 32'h10, 1'b0, 1'b0);
        check("seq_set",    32'(seq_err), 32'd1);
        cyc(1'b1, 32'h14, 1'b1, 1'b0);
        cyc(1'b0, 32'h0,  1'b1, 1'b0);
        check("seq_sticky", 32'(seq_err), 32'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        check("seq_flush",  32'(seq_err), 32'd0);

        // Reset mid-stream with two entries and seq_err set.
        cyc(1'b1, 32'h40, 1'b0, 1'b0);
        cyc(1'b1, 32'h80, 1'b0, 1'b0);
        check("pre_rst_count",   32'(count),   32'd2);
        check("pre_rst_seq_err", 32'(seq_err), 32'd1);
        reset = 1'b1;
        cyc(1'b1, 32'h84, 1'b1, 1'b1);
        reset = 1'b0;
        check("mid_rst_count",     32'(count),     32'd0);
        check("mid_rst_mem_ready", 32'(mem_ready), 32'd1);
        check("mid_rst_seq_err",   32'(seq_err),   32'd0);
        check("mid_rst_dec_valid", 32'(dec_valid), 32'd0);
        cyc(1'b1, 32'h300, 1'b0, 1'b0);
        check("post_rst_seq_err",  32'(seq_err),   32'd0);
        check("post_rst_dec_pc",   dec_pc,         32'h300);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        check("leftover_entries", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_fetch_queue

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning number of instruction entries (power of two, at least 2).
REQ-002 The block SHALL have parameter WORD_W, default 32, meaning instruction and PC width.
REQ-003 The block SHALL have port clk, input, 1, meaning the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-005 The block SHALL have port mem_valid, input, 1, meaning the memory instruction port presents a fetched word this cycle.
REQ-006 The block SHALL have port mem_pc, input, WORD_W, meaning the byte address of the presented instruction.
REQ-007 The block SHALL have port mem_instr, input, WORD_W, meaning the presented instruction word.
REQ-008 The block SHALL have port mem_ready, output, 1, meaning the queue accepts a word this cycle.
REQ-009 The block SHALL have port dec_valid, output, 1, meaning the head entry is valid for decode.
REQ-010 The block SHALL have port dec_instr, output, WORD_W, meaning the head instruction.
REQ-011 The block SHALL have port dec_pc, output, WORD_W, meaning the head instruction's PC.
REQ-012 The block SHALL have port dec_ready, input, 1, meaning decode consumes the head this cycle.
REQ-013 The block SHALL have port flush, input, 1, meaning discard all entries (branch/jump redirect).
REQ-014 The block SHALL have port count, output, clog2(DEPTH)+1, meaning the current occupancy.
REQ-015 The block SHALL have port seq_err, output, 1, meaning sticky PC-discontinuity flag.

Function
REQ-016 The block SHALL push when mem_valid and mem_ready are both high, storing {mem_pc, mem_instr} at the tail.
REQ-017 The block SHALL pop when dec_valid and dec_ready are both high, advancing the head.
REQ-018 The block SHALL drive mem_ready as NOT full, from registered state only, with no combinational path from dec_ready; a full queue refuses a push even when a pop occurs in the same cycle.
REQ-019 The block SHALL perform a push and a pop in the same cycle when not full and not empty, leaving count unchanged.
REQ-020 The block SHALL make a pushed entry visible on dec_valid no earlier than the cycle after the push; there is no flow-through when empty.
REQ-021 The block SHALL drive dec_valid = (count != 0), with dec_instr/dec_pc taken combinationally from the head entry when valid and 0x00000000 (NOP) when empty.
REQ-022 The block SHALL wrap the head and tail pointers modulo DEPTH.
REQ-023 The block SHALL clear count and pointers on flush so that dec_valid is low the following cycle; a push or pop requested in the flush cycle is ignored.
REQ-024 The block SHALL hold an expected-PC register that is loaded with mem_pc+4 on every accepted push (modulo 2^WORD_W) and is invalid after reset or flush.
REQ-025 The block SHALL set seq_err when an accepted push has mem_pc differing from a valid expected PC, and hold it until reset or flush; the first push after reset or flush never sets it.
REQ-026 The block SHALL leave stored entry contents unspecified when not valid; only the outputs are defined.

Reset
REQ-027 The block SHALL, when reset is high at a clock edge, drive count=0, dec_valid=0, dec_instr=0, dec_pc=0, mem_ready=1, seq_err=0, expected-PC invalid.
REQ-028 The block SHALL give reset priority over flush, push and pop; reset mid-stream discards all entries.

Structure
REQ-029 The block SHALL take WORD_W, NOP encoding 0x00000000 and PC_STEP=4 from the shared package mips_pkg.
REQ-030 The block SHALL have no sub-module; storage, pointers and the checker are inline.

Verification
REQ-031 The bench SHALL cover the following: after reset, push PCs 0x0,0x4,0x8 with dec_ready=0 -> count=3, dec_pc=0x0, dec_instr=word0, seq_err=0.
REQ-032 The bench SHALL cover the following: fill 4 entries, hold mem_valid=1 and dec_ready=1 -> mem_ready=0 that cycle, count 4->3, fifth word accepted the next cycle.
REQ-033 The bench SHALL cover the following: 10 streaming push/pop pairs at DEPTH=4 -> pointer wrap, order preserved, dec_pc sequence 0x0..0x24.
REQ-034 The bench SHALL cover the following: with 3 entries queued, flush=1 together with a push of 0x100 -> next cycle count=0, dec_valid=0, dec_instr=0; a following push of 0x200 gives seq_err=0.
REQ-035 The bench SHALL cover the following: push 0x0 then 0x10 -> seq_err=1 the next cycle, remaining high until flush.
REQ-036 The bench SHALL cover the following: reset asserted with 2 entries queued -> next cycle count=0, mem_ready=1, seq_err=0.
